// File: rtl/data_memory.sv
// rtl/data_memory.sv - DEPTH x 32 data memory, async-clear, single write port.
// Optional registered read path selected by macro DMEM_REG_READ_EN.
module data_memory #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mwr,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic          in_range;
  logic [AW-1:0] widx;
  logic [31:0]   rdata;
  logic          unused_addr_bits;

  // Any set bit above the index field means the word lies beyond DEPTH.
  assign in_range         = (addr[31:AW+2] == '0);
  assign widx             = addr[AW+1:2];
  assign unused_addr_bits = ^addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!mwr && in_range) begin
      mem[widx] <= wd;
    end
  end

  assign rdata = (rst_n && in_range) ? mem[widx] : 32'h0000_0000;

`ifdef DMEM_REG_READ_EN
  // Sampled with the pre-edge array contents, so a same-word write returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
    end else begin
      rd <= rdata;
    end
  end
`else
  assign rd = rdata;
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory with a word-array reference model.
// Honours DMEM_REG_READ_EN to match the configured read latency.
module tb_data_memory;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic        mwr;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;

  int checks;
  int failures;
  logic [31:0] model [DEPTH];

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mwr  (mwr),
    .addr (addr),
    .wd   (wd),
    .rd   (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int unsigned idx;
    idx = a / 4;
    if (idx < DEPTH) return model[idx];
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic m, input logic [31:0] a, input logic [31:0] d);
    int unsigned idx;
    @(negedge clk);
    mwr = m; addr = a; wd = d;
    @(posedge clk);
    idx = a / 4;
    if (!m && idx < DEPTH) model[idx] = d;
    #1;
    mwr = 1'b1;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a);
    @(negedge clk);
    mwr = 1'b1; addr = a;
`ifdef DMEM_REG_READ_EN
    @(posedge clk);
`endif
    #1;
    check(tag, rd, ref_read(a));
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  initial begin
    logic [31:0] wa [6];
    logic [31:0] wv [6];
    logic [31:0] ra;
    checks = 0; failures = 0;
    wa = '{32'd4, 32'd8, 32'd12, 32'd24, 32'd36, 32'd52};
    wv = '{32'd56, 32'd22, 32'd86, 32'd33, 32'd56, 32'd96};

    // Reset for two cycles
    rst_n = 1'b0; mwr = 1'b0; addr = 32'd4; wd = 32'h1234_5678;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rd_in_reset", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; mwr = 1'b1;
    read_chk("reset_a0", 32'd0);
    read_chk("reset_a4", 32'd4);
    read_chk("reset_a252", 32'd252);

    // Write/readback on consecutive edges
    for (int i = 0; i < 6; i++) do_write(1'b0, wa[i], wv[i]);
    wd = 32'd96;
    for (int i = 0; i < 6; i++) begin
      read_chk($sformatf("readback_%0d", wa[i]), wa[i]);
      check($sformatf("readback_const_%0d", wa[i]), ref_read(wa[i]), wv[i]);
    end

    // Write inhibit
    @(negedge clk);
    mwr = 1'b1; addr = 32'd8; wd = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("inhibit_a8", rd, 32'd22);

    // Bounds and misalignment
    do_write(1'b0, 32'd256, 32'd7);
    read_chk("oob_read_256", 32'd256);
    read_chk("oob_no_alias_a0", 32'd0);
    do_write(1'b0, 32'h8000_0004, 32'hCAFE_0001);
    read_chk("oob_high_no_alias_a4", 32'd4);
    read_chk("misaligned_a6", 32'd6);
    check("misaligned_a6_const", ref_read(32'd6), 32'd56);
    do_write(1'b0, 32'd43, 32'hA5A5_0F0F);
    read_chk("misaligned_write_a40", 32'd40);

    // Same-word write/read collision
    @(negedge clk);
    mwr = 1'b0; addr = 32'd16; wd = 32'h0BAD_F00D;
    #1;
`ifdef DMEM_REG_READ_EN
    @(posedge clk); #1;
    check("collision_old", rd, ref_read(32'd16));
    model[4] = 32'h0BAD_F00D;
    @(negedge clk); mwr = 1'b1;
    @(posedge clk); #1;
    check("collision_new", rd, 32'h0BAD_F00D);
`else
    check("collision_old", rd, ref_read(32'd16));
    @(posedge clk); #1;
    model[4] = 32'h0BAD_F00D;
    check("collision_new", rd, 32'h0BAD_F00D);
    mwr = 1'b1;
`endif

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      ra = 32'($urandom_range(0, DEPTH * 4 + 63));
      if ($urandom_range(0, 15) == 0) ra = $urandom;
      do_write(1'($urandom_range(0, 1)), ra, $urandom);
      ra = 32'($urandom_range(0, DEPTH * 4 + 63));
      read_chk("random_read", ra);
    end

    // Async reset between edges, mid-write
    @(negedge clk);
    mwr = 1'b0; addr = 32'd52; wd = 32'd123;
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("async_reset_rd", rd, 32'h0);
    @(posedge clk); #1;
    check("reset_blocks_write", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; mwr = 1'b1;
    read_chk("post_reset_a52", 32'd52);
    read_chk("post_reset_a4", 32'd4);
    do_write(1'b0, 32'd20, 32'd9);
    read_chk("first_write_after_reset", 32'd20);

`ifdef DMEM_REG_READ_EN
    // One-cycle read latency
    do_write(1'b0, 32'd16, 32'd5);
    read_chk("latency_prev_a0", 32'd0);
    @(negedge clk);
    addr = 32'd16;
    #1;
    check("latency_not_before", rd, ref_read(32'd0));
    @(posedge clk); #1;
    check("latency_after", rd, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
